// File: rtl/shift_rotate_seq.sv
// shift_rotate_seq: iterative one-bit-per-clock shift/rotate unit with valid/ready request and response ports
module shift_rotate_seq #(
    parameter int WIDTH     = 8,
    parameter int MAX_SHIFT = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_control,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [3:0]       res_flags
);
    localparam int CW = $clog2(MAX_SHIFT + 1);
    localparam int RW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MAXB = WIDTH'(MAX_SHIFT);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_data, w_step;
    logic [CW-1:0] r_cnt, w_n;
    logic [2:0] r_op;
    logic r_cf, r_a7, w_cf, w_right, w_fill_r, w_fill_l, w_accept;
    always_comb begin
        w_n = req_control[2] ? CW'(req_b[RW-1:0]) : (req_b > MAXB ? CW'(MAX_SHIFT) : req_b[CW-1:0]);
        w_accept = !flush && r_state == IDLE && req_valid;
        w_next = flush ? IDLE :
                 r_state == IDLE ? (req_valid ? (w_n == '0 ? DONE : BUSY) : IDLE) :
                 r_state == BUSY ? (r_cnt == CW'(1) ? DONE : BUSY) :
                 (res_ready ? IDLE : DONE);
    end
    // rotates wrap the outgoing bit; arithmetic right replicates the sign bit
    always_comb begin
        w_right = r_op[2] ? r_op[0] : ~r_op[1];
        w_fill_r = r_op[2] ? r_data[0] : (~r_op[0] & r_data[WIDTH-1]);
        w_fill_l = r_op[2] & r_data[WIDTH-1];
        w_step = w_right ? {w_fill_r, r_data[WIDTH-1:1]} : {r_data[WIDTH-2:0], w_fill_l};
        w_cf = w_right ? r_data[0] : r_data[WIDTH-1];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_data <= '0;
            r_cnt <= '0;
            r_op <= '0;
            r_cf <= 1'b0;
            r_a7 <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data <= req_a;
                r_op <= req_control;
                r_cnt <= w_n;
                r_cf <= 1'b0;
                r_a7 <= req_a[WIDTH-1];
            end else if (!flush && r_state == BUSY) begin
                r_data <= w_step;
                r_cf <= w_cf;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
    always_comb begin
        req_ready = r_state == IDLE;
        res_valid = r_state == DONE;
        res_data = r_data;
        res_flags = r_state == DONE ? {r_cf, ~|r_data, r_data[WIDTH-1], ~r_op[2] & (r_a7 ^ r_data[WIDTH-1])} : 4'b0000;
    end
endmodule

// File: tb/tb_shift_rotate_seq.sv
// tb_shift_rotate_seq: directed self-checking bench for shift_rotate_seq
module tb_shift_rotate_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0, req_ready, flush = 1'b0, res_valid, res_ready = 1'b0;
    logic [7:0] req_a = '0, req_b = '0, res_data;
    logic [2:0] req_control = '0;
    logic [3:0] res_flags;
    int errors = 0, checks = 0;

    shift_rotate_seq dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_control(req_control), .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] c;
        int lat;
        logic [7:0] d;
        logic [3:0] f;
        string name;
    } vec_t;

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                         output int lat, output logic [7:0] d, output logic [3:0] f);
        req_a = a; req_b = b; req_control = c; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) lat = -1;
        d = res_data; f = res_flags;
    endtask

    task automatic finish_op;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 8'h00 || res_flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b data=%h flags=%b, need rdy=1 vld=0 data=00 flags=0000",
                     req_ready, res_valid, res_data, res_flags);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vectors(input vec_t v[]);
        int lat;
        logic [7:0] d;
        logic [3:0] f;
        foreach (v[i]) begin
            do_op(v[i].a, v[i].b, v[i].c, lat, d, f);
            checks++;
            if (lat !== v[i].lat || d !== v[i].d || f !== v[i].f) begin
                errors++;
                $display("FAIL %s: got lat=%0d data=%h flags=%b, need lat=%0d data=%h flags=%b",
                         v[i].name, lat, d, f, v[i].lat, v[i].d, v[i].f);
            end
            finish_op();
            checks++;
            if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_return: got rdy=%b vld=%b, need rdy=1 vld=0", v[i].name, req_ready, res_valid);
            end
        end
    endtask

    task automatic test_shifts;
        vec_t v[] = '{
            '{8'h81, 8'd1,   3'b000, 2,  8'hC0, 4'b1010, "sar_1"},
            '{8'h81, 8'd3,   3'b001, 4,  8'h10, 4'b0001, "shr_3"},
            '{8'h81, 8'd1,   3'b010, 2,  8'h02, 4'b1001, "shl_1"},
            '{8'h81, 8'd8,   3'b011, 9,  8'h00, 4'b1101, "shl_8"},
            '{8'h81, 8'd200, 3'b011, 10, 8'h00, 4'b0101, "shl_sat9"},
            '{8'h81, 8'd8,   3'b001, 9,  8'h00, 4'b1101, "shr_8"},
            '{8'h81, 8'd8,   3'b000, 9,  8'hFF, 4'b1010, "sar_8"},
            '{8'h40, 8'd9,   3'b000, 10, 8'h00, 4'b0100, "sar_9_pos"},
            '{8'h5A, 8'd0,   3'b001, 1,  8'h5A, 4'b0000, "shr_0"}
        };
        run_vectors(v);
    endtask

    task automatic test_rotates;
        vec_t v[] = '{
            '{8'h01, 8'd1, 3'b101, 2, 8'h80, 4'b1010, "ror_1"},
            '{8'h80, 8'd9, 3'b100, 2, 8'h01, 4'b1000, "rol_9"},
            '{8'h96, 8'd3, 3'b111, 4, 8'hD2, 4'b1010, "ror_3_ctl111"},
            '{8'h96, 8'd2, 3'b110, 3, 8'h5A, 4'b0000, "rol_2_ctl110"},
            '{8'hA5, 8'd0, 3'b100, 1, 8'hA5, 4'b0010, "rol_0"},
            '{8'h00, 8'd8, 3'b101, 1, 8'h00, 4'b0100, "ror_8_is_0"}
        };
        run_vectors(v);
    endtask

    task automatic test_backpressure;
        int lat;
        logic [7:0] d;
        logic [3:0] f;
        do_op(8'h81, 8'd3, 3'b001, lat, d, f);
        checks++;
        if (lat !== 4 || d !== 8'h10 || f !== 4'b0001) begin
            errors++;
            $display("FAIL bp_result: got lat=%0d data=%h flags=%b, need lat=4 data=10 flags=0001", lat, d, f);
        end
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 2);
            req_a = 8'hFF; req_b = 8'd1; req_control = 3'b001;
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_data !== 8'h10 || res_flags !== 4'b0001) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b data=%h flags=%b, need vld=1 rdy=0 data=10 flags=0001",
                         i, res_valid, req_ready, res_data, res_flags);
            end
        end
        req_valid = 1'b0;
        finish_op();
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b vld=%b, need rdy=1 vld=0", req_ready, res_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ignored_req: got vld=%b rdy=%b, need vld=0 rdy=1", res_valid, req_ready);
        end
    endtask

    task automatic test_flush_reset;
        int seen = 0;
        int lat;
        logic [7:0] d;
        logic [3:0] f;
        req_a = 8'h81; req_b = 8'd5; req_control = 3'b001; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: got rdy=%b, need rdy=0", req_ready);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got rdy=%b vld=%b, need rdy=1 vld=0", req_ready, res_valid);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_no_result: got %0d valid cycles, need 0", seen);
        end
        req_a = 8'h81; req_b = 8'd5; req_control = 3'b000; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 8'h00 || res_flags !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b vld=%b data=%h flags=%b, need rdy=1 vld=0 data=00 flags=0000",
                     req_ready, res_valid, res_data, res_flags);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || res_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: got vld=%b data=%h, need vld=0 data=00", res_valid, res_data);
        end
        do_op(8'h80, 8'd9, 3'b000, lat, d, f);
        checks++;
        if (lat !== 10 || d !== 8'hFF || f !== 4'b1010) begin
            errors++;
            $display("FAIL after_reset_op: got lat=%0d data=%h flags=%b, need lat=10 data=FF flags=1010", lat, d, f);
        end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_shifts();
        test_rotates();
        test_backpressure();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
